niosii_system_st_packet_arbiter: RTL

- Two-input, packet-aware round-robin arbiter that shares one 8-bit Avalon-ST byte stream (data/sop/eop, ready/valid) between two requesters. Example requesters: the camera/gesture byte path and a CPU-side packet source.
- Sits in front of the system's ST timing adapters and sink.
- Grants on start-of-packet and holds the grant until the granted packet's end-of-packet.
- Drives a one-deep registered output stage and keeps per-input packet counters and a drop counter for software debug.

---
 rtl/niosii_system_st_packet_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/niosii_system_st_packet_arbiter.sv
// Two-input packet-aware round-robin arbiter for an Avalon-ST byte stream.
// The grant is taken on SOP, held until the granted packet's EOP, and feeds a one-deep output register.
module niosii_system_st_packet_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_startofpacket,
  input  logic              in0_endofpacket,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_startofpacket,
  input  logic              in1_endofpacket,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  input  logic              out_ready,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e              state_q;
  logic                prio_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_sop_q;
  logic                out_eop_q;
  logic [CNT_W-1:0]    pkt_cnt0_q;
  logic [CNT_W-1:0]    pkt_cnt1_q;
  logic [CNT_W-1:0]    drop_cnt_q;

  logic                can_load;
  logic                acc0;
  logic                acc1;
  logic                req0;
  logic                req1;
  logic                drop0;
  logic                drop1;
  logic                load;
  logic [DATA_W-1:0]   load_data;
  logic                load_sop;
  logic                load_eop;
  logic [CNT_W:0]      drop_sum;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign can_load = !out_valid_q || out_ready;
  assign req0     = in0_valid && in0_startofpacket;
  assign req1     = in1_valid && in1_startofpacket;

  // Ready is forced low while reset is held so no handshake can be seen during reset.
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          in0_ready = in0_valid && !in0_startofpacket;
          in1_ready = in1_valid && !in1_startofpacket;
        end
        LOCK0:   in0_ready = can_load;
        LOCK1:   in1_ready = can_load;
        default: ;
      endcase
    end
  end

  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;
  assign drop0     = acc0 && (state_q == IDLE);
  assign drop1     = acc1 && (state_q == IDLE);
  assign load      = ((state_q == LOCK0) && acc0) || ((state_q == LOCK1) && acc1);
  assign load_data = (state_q == LOCK1) ? in1_data : in0_data;
  assign load_sop  = (state_q == LOCK1) ? in1_startofpacket : in0_startofpacket;
  assign load_eop  = (state_q == LOCK1) ? in1_endofpacket : in0_endofpacket;
  assign drop_sum  = {1'b0, drop_cnt_q} + {{CNT_W{1'b0}}, drop0} + {{CNT_W{1'b0}}, drop1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      pkt_cnt0_q  <= '0;
      pkt_cnt1_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 && (!req1 || !prio_q)) state_q <= LOCK0;
          else if (req1)                  state_q <= LOCK1;
        end
        LOCK0: begin
          if (acc0 && in0_endofpacket) begin
            state_q    <= IDLE;
            prio_q     <= 1'b1;
            pkt_cnt0_q <= sat_inc(pkt_cnt0_q);
          end
        end
        LOCK1: begin
          if (acc1 && in1_endofpacket) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            pkt_cnt1_q <= sat_inc(pkt_cnt1_q);
          end
        end
        default: state_q <= IDLE;
      endcase

      // A load wins over a drain, so back-to-back beats keep out_valid high.
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= load_data;
        out_sop_q   <= load_sop;
        out_eop_q   <= load_eop;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      drop_cnt_q <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

  assign grant             = {state_q == LOCK1, state_q == LOCK0};
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign pkt_cnt0          = pkt_cnt0_q;
  assign pkt_cnt1          = pkt_cnt1_q;
  assign drop_cnt          = drop_cnt_q;

endmodule
